// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: grant-tag encodings and default widths.
package vram_arbiter_pkg;

    localparam int AWIDTH_DEF = 11;
    localparam int DWIDTH_DEF = 16;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_CPU_RD = 2'd1,
        TAG_CPU_WR = 2'd2,
        TAG_VID    = 2'd3
    } grant_tag_t;

endpackage

// File: rtl/vram_arbiter_starve_counter.sv
// Saturating count of cycles the CPU has been kept off the RAM port;
// hit flags that the limit has been reached.
module arb_starve_counter #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && count != CW'(MAX)) begin
            count <= count + CW'(1);
        end
    end

    assign hit = (count == CW'(MAX));

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between CPU bus and VGA scanout; video has priority.
// Optional CPU starvation guard enabled by defining VRAM_ARB_STARVE_EN.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [AWIDTH-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_valid,
    output logic [DWIDTH-1:0] vid_rdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_we,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata
);

    logic              vid_grant;
    logic              cpu_grant;
    logic              cpu_pending;
    logic              cpu_force;
    grant_tag_t        tag;
    logic [DWIDTH-1:0] cpu_rdata_q;
    logic [DWIDTH-1:0] vid_rdata_q;

`ifdef VRAM_ARB_STARVE_EN
    logic starve_hit;

    // Cycles spent waiting on an already-served request do not count as starvation.
    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (cpu_req && !cpu_grant && !cpu_pending),
        .clr   (cpu_grant),
        .hit   (starve_hit)
    );

    assign cpu_force = starve_hit && cpu_req && !cpu_pending;
`else
    assign cpu_force = 1'b0;
`endif

    assign vid_grant = !reset && vid_req && !cpu_force;
    assign cpu_grant = !reset && cpu_req && !vid_grant && !cpu_pending;
    assign vid_gnt   = vid_grant;
    assign ram_wdata = cpu_wdata;

    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        if (vid_grant) begin
            ram_addr = vid_addr;
        end else if (cpu_grant) begin
            ram_addr = cpu_addr;
            ram_we   = cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag         <= TAG_NONE;
            cpu_pending <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            cpu_pending <= cpu_grant;
            if (vid_grant) begin
                tag <= TAG_VID;
            end else if (cpu_grant) begin
                tag <= cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            end else begin
                tag <= TAG_NONE;
            end
            if (tag == TAG_CPU_RD) cpu_rdata_q <= ram_rdata;
            if (tag == TAG_VID)    vid_rdata_q <= ram_rdata;
        end
    end

    // The RAM's own output register supplies the data in the ack cycle; the
    // hold registers keep it afterwards. Reset masks anything still in flight.
    assign cpu_ack   = !reset && (tag == TAG_CPU_RD || tag == TAG_CPU_WR);
    assign vid_valid = !reset && (tag == TAG_VID);
    assign cpu_rdata = reset ? '0 : (tag == TAG_CPU_RD) ? ram_rdata : cpu_rdata_q;
    assign vid_rdata = reset ? '0 : (tag == TAG_VID)    ? ram_rdata : vid_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected read data,
// a negedge monitor pops and compares on cpu_ack / vid_valid.
module tb_vram_arbiter;

    localparam int AW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt, vid_valid;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_cpu_q[$];
    logic [DW-1:0] exp_vid_q[$];
    logic [DW-1:0] last_rd = '0;

    vram_arbiter #(
        .AWIDTH     (AW),
        .DWIDTH     (DW),
        .STARVE_MAX (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_gnt   (vid_gnt),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM the arbiter drives.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_port(input string name, input logic gnt, input logic we,
                               input logic [AW-1:0] addr);
        check({name, "_vid_gnt"},  32'(vid_gnt),  32'(gnt));
        check({name, "_ram_we"},   32'(ram_we),   32'(we));
        check({name, "_ram_addr"}, 32'(ram_addr), 32'(addr));
    endtask

    // Monitor: pops an expectation whenever the DUT presents a completion.
    always @(negedge clk) begin
        if (cpu_ack === 1'b1) begin
            if (exp_cpu_q.size() == 0) check("cpu_ack_spurious", 32'(cpu_ack), 32'd0);
            else check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_q.pop_front()));
        end
        if (vid_valid === 1'b1) begin
            if (exp_vid_q.size() == 0) check("vid_valid_spurious", 32'(vid_valid), 32'd0);
            else check("vid_rdata", 32'(vid_rdata), 32'(exp_vid_q.pop_front()));
        end
    end

    initial begin
        int k;
        int cpu_gnt_cycle;

        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;

        // Reset: requests present but nothing granted, all outputs zero.
        tick();
        vid_req = 1'b1; vid_addr = 11'h003; cpu_req = 1'b1; cpu_addr = 11'h004;
        sample();
        expect_port("rst", 1'b0, 1'b0, 11'h000);
        check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        check("rst_vid_valid", 32'(vid_valid), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_vid_rdata", 32'(vid_rdata), 32'd0);
        tick();
        reset = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
        tick();

        // Video streak 0..9: granted every cycle, data one cycle later.
        for (int i = 0; i < 10; i++) begin
            tick();
            vid_req = 1'b1; vid_addr = AW'(i);
            exp_vid_q.push_back(DW'(i));
            sample();
            expect_port("vid_stream", 1'b1, 1'b0, AW'(i));
            check("vid_stream_valid", 32'(vid_valid), 32'(i > 0));
        end
        tick();
        vid_req = 1'b0;
        sample();
        check("vid_stream_last_valid", 32'(vid_valid), 32'd1);
        tick();
        sample();
        check("vid_stream_idle_valid", 32'(vid_valid), 32'd0);

        // CPU write 0x1234 @0x005, then read it back.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h005; cpu_wdata = 16'h1234;
        exp_cpu_q.push_back(last_rd);
        sample();
        expect_port("cpu_wr", 1'b0, 1'b1, 11'h005);
        check("cpu_wr_wdata", 32'(ram_wdata), 32'h1234);
        check("cpu_wr_ack_early", 32'(cpu_ack), 32'd0);
        tick();
        cpu_req = 1'b0;
        sample();
        check("cpu_wr_ack", 32'(cpu_ack), 32'd1);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005;
        exp_cpu_q.push_back(16'h1234); last_rd = 16'h1234;
        sample();
        expect_port("cpu_rd", 1'b0, 1'b0, 11'h005);
        tick();
        cpu_req = 1'b0;
        sample();
        check("cpu_rd_ack", 32'(cpu_ack), 32'd1);
        tick();

        // Simultaneous requests: video wins until vid_req drops.
        for (int i = 0; i < 3; i++) begin
            tick();
            vid_req = 1'b1; vid_addr = AW'(32'h20 + i);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h030;
            exp_vid_q.push_back(DW'(32'h20 + i));
            sample();
            expect_port("both_vid", 1'b1, 1'b0, AW'(32'h20 + i));
        end
        tick();
        vid_req = 1'b0;
        exp_cpu_q.push_back(16'h0030); last_rd = 16'h0030;
        sample();
        expect_port("both_cpu", 1'b0, 1'b0, 11'h030);
        tick();
        cpu_req = 1'b0;
        sample();
        check("both_cpu_ack", 32'(cpu_ack), 32'd1);
        tick();

        // Continuous video against a CPU read: forced on cycle 9 only with the guard.
`ifdef VRAM_ARB_STARVE_EN
        cpu_gnt_cycle = 9;
`else
        cpu_gnt_cycle = 100;
`endif
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            vid_req = 1'b1; vid_addr = AW'(32'h50 + k);
            cpu_req = (c <= cpu_gnt_cycle); cpu_we = 1'b0; cpu_addr = 11'h040;
            if (c == cpu_gnt_cycle) begin
                exp_cpu_q.push_back(16'h0040); last_rd = 16'h0040;
            end else begin
                exp_vid_q.push_back(DW'(32'h50 + k));
            end
            sample();
            if (c == cpu_gnt_cycle) begin
                expect_port("starve_cpu", 1'b0, 1'b0, 11'h040);
            end else begin
                expect_port("starve_vid", 1'b1, 1'b0, AW'(32'h50 + k));
                k++;
            end
            check("starve_cpu_ack", 32'(cpu_ack), 32'(c == cpu_gnt_cycle + 1));
        end
        tick();
        vid_req = 1'b0; cpu_req = 1'b0;
        tick();

        // Reset in the cycle after a CPU grant drops the ack; reissue completes.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h007;
        sample();
        expect_port("rstmid_gnt", 1'b0, 1'b0, 11'h007);
        tick();
        reset = 1'b1; vid_req = 1'b1; vid_addr = 11'h009;
        sample();
        expect_port("rstmid", 1'b0, 1'b0, 11'h000);
        check("rstmid_cpu_ack",   32'(cpu_ack),   32'd0);
        check("rstmid_vid_valid", 32'(vid_valid), 32'd0);
        check("rstmid_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rstmid_vid_rdata", 32'(vid_rdata), 32'd0);
        tick();
        reset = 1'b0; vid_req = 1'b0;
        exp_cpu_q.push_back(16'h0007); last_rd = 16'h0007;
        sample();
        expect_port("rstmid_reissue", 1'b0, 1'b0, 11'h007);
        check("rstmid_no_late_ack", 32'(cpu_ack), 32'd0);
        tick();
        cpu_req = 1'b0;
        sample();
        check("rstmid_reissue_ack", 32'(cpu_ack), 32'd1);
        tick();

        // Back-to-back reads with req held: acks two cycles apart, no repeat of 0x000.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h000;
        exp_cpu_q.push_back(16'h0000);
        sample();
        expect_port("b2b_first", 1'b0, 1'b0, 11'h000);
        tick();
        cpu_addr = 11'h001;
        exp_cpu_q.push_back(16'h0001); last_rd = 16'h0001;
        sample();
        check("b2b_ack0", 32'(cpu_ack), 32'd1);
        check("b2b_blocked_we", 32'(ram_we), 32'd0);
        tick();
        sample();
        check("b2b_no_dup_ack", 32'(cpu_ack), 32'd0);
        expect_port("b2b_second", 1'b0, 1'b0, 11'h001);
        tick();
        cpu_req = 1'b0;
        sample();
        check("b2b_ack1", 32'(cpu_ack), 32'd1);

        // A write ack leaves cpu_rdata at the last read value.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h008; cpu_wdata = 16'hBEEF;
        exp_cpu_q.push_back(last_rd);
        sample();
        expect_port("hold_wr", 1'b0, 1'b1, 11'h008);
        tick();
        cpu_req = 1'b0;
        sample();
        check("hold_wr_ack", 32'(cpu_ack), 32'd1);
        check("hold_mem", 32'(mem[8]), 32'hBEEF);

        tick(); tick(); tick();
        check("cpu_queue_drained", 32'(exp_cpu_q.size()), 32'd0);
        check("vid_queue_drained", 32'(exp_vid_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
